// File: rtl/screen_state_ctrl_if.sv
// Screen controller bus: keyboard/game-status inputs and screen-selection outputs.
// Also carries the screen-code enumeration shared by the controller and its users.
package screen_state_ctrl_pkg;
    typedef enum logic [3:0] {
        ST_LS = 4'b0001,
        ST_GO = 4'b0010,
        ST_L1 = 4'b0011,
        ST_L2 = 4'b0100,
        ST_L3 = 4'b0101,
        ST_L4 = 4'b0110,
        ST_L5 = 4'b0111,
        ST_L6 = 4'b1000,
        ST_L7 = 4'b1001,
        ST_L8 = 4'b1010,
        ST_SM = 4'b1111
    } state_t;
endpackage

interface screen_state_ctrl_if;
    logic [3:0] level_in;
    logic       other_in;
    logic       win;
    logic       lose;
    logic [3:0] current_state;
    logic       level_start;
    logic       game_active;

    modport master (
        output level_in, other_in, win, lose,
        input  current_state, level_start, game_active
    );

    modport slave (
        input  level_in, other_in, win, lose,
        output current_state, level_start, game_active
    );
endinterface

// File: rtl/screen_state_ctrl.sv
// Game screen sequencer (start menu, level select, levels, game over) with a post-change input hold-off.
// Optional macro WIN_ADVANCE_EN: a win advances to the next level instead of returning to level select.
module screen_state_ctrl
    import screen_state_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    screen_state_ctrl_if.slave   bus
);

    localparam int unsigned HOLD_W = 26;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    logic [HOLD_W-1:0]   hold;
    logic                other_q;
    logic                level_start_q;
    logic                game_active_q;

    logic                expired_c;
    logic                rise_c;
    logic                level_ok_c;
    state_t              level_target_c;

    assign expired_c      = (hold == '0);
    assign rise_c         = bus.other_in & ~other_q;
    assign level_ok_c     = (bus.level_in >= 4'd1) && (bus.level_in <= 4'd8);
    assign level_target_c = state_t'(4'(bus.level_in + 4'd2));

    // Every state change reloads the hold counter; inputs are only acted on once it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_SM;
            hold          <= HOLD_LOAD;
            other_q       <= 1'b1;
            level_start_q <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            other_q       <= bus.other_in;
            level_start_q <= 1'b0;
            if (!expired_c) begin
                hold <= hold - HOLD_W'(1);
            end

            case (state)
                ST_SM: begin
                    if (expired_c && rise_c) begin
                        state <= ST_LS;
                        hold  <= HOLD_LOAD;
                    end
                end
                ST_LS: begin
                    if (expired_c && rise_c && level_ok_c) begin
                        state         <= level_target_c;
                        hold          <= HOLD_LOAD;
                        level_start_q <= 1'b1;
                        game_active_q <= 1'b1;
                    end
                end
                ST_GO: begin
                    if (expired_c && rise_c) begin
                        state <= ST_SM;
                        hold  <= HOLD_LOAD;
                    end
                end
                ST_L1, ST_L2, ST_L3, ST_L4, ST_L5, ST_L6, ST_L7, ST_L8: begin
                    // Win outranks lose when both are raised together.
                    if (expired_c && bus.win) begin
                        hold <= HOLD_LOAD;
`ifdef WIN_ADVANCE_EN
                        if (state != ST_L8) begin
                            state         <= state_t'(4'(state + 4'd1));
                            level_start_q <= 1'b1;
                        end else begin
                            state         <= ST_LS;
                            game_active_q <= 1'b0;
                        end
`else
                        state         <= ST_LS;
                        game_active_q <= 1'b0;
`endif
                    end else if (expired_c && bus.lose) begin
                        state         <= ST_GO;
                        hold          <= HOLD_LOAD;
                        game_active_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_SM;
                    hold          <= HOLD_LOAD;
                    game_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.current_state = state;
    assign bus.level_start   = level_start_q;
    assign bus.game_active   = game_active_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Bench for screen_state_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic against a screen-level reference model (HOLD_CYCLES = 4).
module tb_screen_state_ctrl;

    localparam int HOLD = 4;

    logic clk;
    logic rst;

    screen_state_ctrl_if bus ();

    screen_state_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic r, input logic [3:0] lvl, input logic o,
                        input logic w, input logic l);
        rst          = r;
        bus.level_in = lvl;
        bus.other_in = o;
        bus.win      = w;
        bus.lose     = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(string tag, logic [3:0] st, logic ls, logic ga);
        check({tag, ".state"}, bus.current_state, st);
        check({tag, ".level_start"}, {3'b0, bus.level_start}, {3'b0, ls});
        check({tag, ".game_active"}, {3'b0, bus.game_active}, {3'b0, ga});
    endtask

    // Directed vectors: inputs applied for one edge, outputs expected right after it.
    typedef struct {
        logic       rst;
        logic [3:0] level;
        logic       other;
        logic       win;
        logic       lose;
        logic [3:0] st;
        logic       ls;
        logic       ga;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [3:0] lvl, logic o, logic w, logic l,
                                logic [3:0] st, logic ls, logic ga);
        vec_t v;
        v.rst = r; v.level = lvl; v.other = o; v.win = w; v.lose = l;
        v.st = st; v.ls = ls; v.ga = ga;
        vecs.push_back(v);
    endfunction

    // Reference model: screen kind plus level number, and cycles elapsed since the last change.
    localparam int M_SM = 0, M_LS = 1, M_GO = 2, M_LVL = 3;
    int   m_mode;
    int   m_lvl;
    int   m_since;
    bit   m_prev;
    bit   m_ls;

    task automatic model_step(logic r, logic [3:0] lvl, logic o, logic w, logic l);
        int  nm;
        int  nl;
        bit  rise;
        bit  ok;
        if (r) begin
            m_mode = M_SM; m_lvl = 0; m_since = 0; m_prev = 1'b1; m_ls = 1'b0;
        end else begin
            rise   = o && !m_prev;
            m_prev = o;
            if (m_since < 1000) m_since++;
            ok = (m_since >= HOLD);
            nm = m_mode;
            nl = m_lvl;
            if (ok) begin
                case (m_mode)
                    M_SM: if (rise) nm = M_LS;
                    M_LS: if (rise && int'(lvl) >= 1 && int'(lvl) <= 8) begin
                        nm = M_LVL; nl = int'(lvl);
                    end
                    M_GO: if (rise) nm = M_SM;
                    default: begin
                        if (w) begin
`ifdef WIN_ADVANCE_EN
                            if (m_lvl < 8) nl = m_lvl + 1;
                            else nm = M_LS;
`else
                            nm = M_LS;
`endif
                        end else if (l) begin
                            nm = M_GO;
                        end
                    end
                endcase
            end
            m_ls = 1'b0;
            if (nm != m_mode || (nm == M_LVL && nl != m_lvl)) begin
                m_since = 0;
                m_ls    = (nm == M_LVL);
            end
            m_mode = nm;
            m_lvl  = nl;
        end
    endtask

    function automatic logic [3:0] model_code();
        case (m_mode)
            M_SM:    return 4'hF;
            M_LS:    return 4'h1;
            M_GO:    return 4'h2;
            default: return 4'(m_lvl + 2);
        endcase
    endfunction

    // Reset, then walk SM -> LS -> Ln with the hold window drained at each stop.
    task automatic reach_level(int n);
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 4'(n), 0, 0, 0);
        step(0, 4'(n), 1, 0, 0);
        repeat (3) step(0, 4'(n), 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r, o, w, l;
        logic [3:0] lvl;

        rst = 1'b1; bus.level_in = '0; bus.other_in = 1'b1; bus.win = 1'b0; bus.lose = 1'b0;
        @(negedge clk);

        // Held key across reset, invalid levels, edges during hold, GO hold-off, win+lose in L3.
        add(1,0,1,0,0, 4'hF,0,0);
        add(0,0,1,0,0, 4'hF,0,0);
        add(0,0,1,0,0, 4'hF,0,0);
        add(0,0,0,0,0, 4'hF,0,0);
        add(0,0,0,0,0, 4'hF,0,0);
        add(0,0,1,0,0, 4'h1,0,0);
        add(0,5,0,0,0, 4'h1,0,0);
        add(0,5,1,0,0, 4'h1,0,0);
        add(0,5,0,0,0, 4'h1,0,0);
        add(0,5,0,0,0, 4'h1,0,0);
        add(0,0,1,0,0, 4'h1,0,0);
        add(0,9,0,0,0, 4'h1,0,0);
        add(0,9,1,0,0, 4'h1,0,0);
        add(0,5,0,0,0, 4'h1,0,0);
        add(0,5,1,0,0, 4'h7,1,1);
        add(0,5,1,0,0, 4'h7,0,1);
        add(0,5,0,0,0, 4'h7,0,1);
        add(0,5,1,0,0, 4'h7,0,1);
        add(0,5,0,0,0, 4'h7,0,1);
        add(0,5,1,0,0, 4'h7,0,1);
        add(0,5,1,0,1, 4'h2,0,0);
        add(0,0,0,0,0, 4'h2,0,0);
        add(0,0,1,0,0, 4'h2,0,0);
        add(0,0,0,0,0, 4'h2,0,0);
        add(0,0,1,0,0, 4'hF,0,0);
        add(0,0,0,0,0, 4'hF,0,0);
        add(0,0,0,0,0, 4'hF,0,0);
        add(0,0,0,0,0, 4'hF,0,0);
        add(0,0,1,0,0, 4'h1,0,0);
        add(0,3,0,0,0, 4'h1,0,0);
        add(0,3,0,0,0, 4'h1,0,0);
        add(0,3,0,0,0, 4'h1,0,0);
        add(0,3,1,0,0, 4'h5,1,1);
        add(0,3,0,1,1, 4'h5,0,1);
        add(0,3,0,0,0, 4'h5,0,1);
        add(0,3,0,0,0, 4'h5,0,1);
`ifdef WIN_ADVANCE_EN
        add(0,3,0,1,1, 4'h6,1,1);
`else
        add(0,3,0,1,1, 4'h1,0,0);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].level, vecs[i].other, vecs[i].win, vecs[i].lose);
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ls, vecs[i].ga);
        end

        // L8 win returns to level select in both builds.
        reach_level(8);
        check_out("l8_entry_held", 4'hA, 0, 1);
        step(0, 8, 0, 1, 0);
        check_out("l8_win", 4'h1, 0, 0);

        // Reset mid-game wins over win/lose.
        reach_level(2);
        step(1, 2, 1, 1, 1);
        check_out("reset_midgame", 4'hF, 0, 0);

        // Randomized traffic against the model.
        o = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r   = (i == 0) || ($urandom_range(0, 299) == 0);
            lvl = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) o = ~o;
            w   = ($urandom_range(0, 9) == 0);
            l   = ($urandom_range(0, 11) == 0);
            step(r, lvl, o, w, l);
            model_step(r, lvl, o, w, l);
            check_out($sformatf("rand%0d", i), model_code(), m_ls, m_mode == M_LVL);
        end

        // Illegal code recovery, then a full hold window before inputs take effect again.
        step(1, 5, 0, 0, 0);
        repeat (3) step(0, 5, 0, 1, 1);
        @(negedge clk);
        force dut.state = screen_state_ctrl_pkg::state_t'(4'b1100);
        #1;
        check("forced_code", bus.current_state, 4'hC);
        @(posedge clk);
        #1;
        release dut.state;
        #1;
        if (bus.current_state == 4'hC) begin
            @(posedge clk);
            #1;
        end
        check("illegal_recover", bus.current_state, 4'hF);
        check("illegal_game_active", {3'b0, bus.game_active}, 4'h0);
        step(0, 5, 1, 1, 1);
        check("illegal_hold1", bus.current_state, 4'hF);
        step(0, 5, 0, 1, 1);
        check("illegal_hold2", bus.current_state, 4'hF);
        step(0, 5, 1, 1, 1);
        check("illegal_hold3", bus.current_state, 4'hF);
        step(0, 5, 0, 1, 1);
        check("illegal_hold4", bus.current_state, 4'hF);
        step(0, 5, 1, 1, 1);
        check("illegal_after_hold", bus.current_state, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/screen_state_ctrl.md
SCREEN_STATE_CTRL -- requirements
Module: screen_state_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50000000, meaning input-ignore window after every state change (0.5 s at 100 MHz); legal range 1..2^26-1.
REQ-002 SHALL have port clk  input  1  100 MHz system clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port level_in  input  4  keyboard level code; 1..8 valid, others ignored.
REQ-005 SHALL have port other_in  input  1  keyboard confirm key, level-sensitive.
REQ-006 SHALL have port win  input  1  active level's win flag.
REQ-007 SHALL have port lose  input  1  active level's endgame flag.
REQ-008 SHALL have port current_state  output  4  screen code consumed by the VGA/score mux.
REQ-009 SHALL have port level_start  output  1  one-cycle pulse on entry to any level state.
REQ-010 SHALL have port game_active  output  1  high while current_state is L1..L8.

Function
REQ-011 SHALL encode states as follows: SM=1111, LS=0001, GO=0010, and L1..L8=0011..1010 (Ln = n+2).
REQ-012 SHALL register current_state directly from the state flop, with no combinational path from inputs.
REQ-013 SHALL register other_in once and detect a rising edge (other_in=1, previous=0); only edges drive transitions.
REQ-014 SHALL maintain a 26-bit hold counter that loads HOLD_CYCLES-1 on every state change and decrements to 0, saturating at 0.
REQ-015 SHALL treat hold as expired when the counter is 0; all transitions are blocked while hold is not expired, and edges occurring during hold are discarded, not queued.
REQ-016 SHALL transition SM -> LS on an other_in rising edge.
REQ-017 SHALL transition LS -> Ln on an other_in rising edge when level_in=n with 1<=n<=8; with level_in outside 1..8 the state stays LS.
REQ-018 SHALL transition Ln -> GO when lose=1.
REQ-019 SHALL transition Ln -> LS when win=1 (base behaviour; see REQ-027).
REQ-020 SHALL give win priority when win and lose are both 1 in the same cycle.
REQ-021 SHALL ignore other_in edges in Ln.
REQ-022 SHALL transition GO -> SM on an other_in rising edge.
REQ-023 SHALL take every transition one cycle after the qualifying input is sampled; level_start is asserted in the first cycle current_state holds the new Ln.
REQ-024 SHALL drive game_active as a registered signal, equal to (current_state in L1..L8), and in the same cycle as current_state.
REQ-025 SHALL recover from an illegal state code (0000, 1011..1110) to SM on the next cycle, with hold reloaded.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, set state=SM, hold counter=HOLD_CYCLES-1, other_in edge register=1 (so a held key does not fire), level_start=0 and game_active=0; reset mid-game returns to SM regardless of win/lose.

Configuration
REQ-027 SHALL support macro WIN_ADVANCE_EN: when defined, Ln -> L(n+1) on win for n=1..7 (level_start pulses) and L8 -> LS on win; when undefined, every Ln -> LS on win per REQ-019.

Verification (HOLD_CYCLES=4)
REQ-028 SHALL verify: rst 1 cycle with other_in held 1 -> current_state=1111 and stays 1111 until other_in drops and rises again, then 0001.
REQ-029 SHALL verify: in LS after hold, level_in=5 plus an other_in edge -> current_state=0111 one cycle later, level_start=1 for exactly 1 cycle, and game_active=1.
REQ-030 SHALL verify: in LS, level_in=0 or 9 plus an other_in edge -> current_state remains 0001 and level_start=0.
REQ-031 SHALL verify: in L3 with win=1 and lose=1 in the same cycle -> 0001 (macro off) or 0110 (macro on); in L8 with win -> 0001 in both builds.
REQ-032 SHALL verify: entering GO, then an other_in edge 2 cycles later -> ignored, remains 0010; an edge after 4+ cycles -> 1111.
REQ-033 SHALL verify: state forced to 1100 -> current_state=1111 next cycle, and win, lose and other_in are ignored for 4 cycles.
